frame_rx: RTL
=============

# frame_rx

Receive-side framing decoder for the board's UART link. Consumes the byte strobe stream from `UART_RX_CTRL` (`recv_data`/`vald_data`) and recognises frames of the form SOH, STX, payload, ETX, EOT, the format emitted by the button-triggered message sender. It buffers the payload, flags completion with length, and then streams the payload bytes out over a valid/ready handshake. Framing faults are reported as one-cycle error pulses with a code.

## Interface
- `MAX_LEN`, 16: payload buffer depth in bytes; ETX/EOT are not stored.
- `LEN_W`, 5: width of `frame_len`; must be at least clog2(MAX_LEN+1).
- `TIMEOUT_CYC`, 1_000_000: inter-byte timeout in CLK cycles. Used only with `FRAME_RX_TIMEOUT_EN`.
- `CLK` in 1: system clock (E3).
- `RST_N` in 1: reset, asynchronous, active-low.
- `recv_data` in 8: received byte; sampled only when `vald_data`=1.
- `vald_data` in 1: one-cycle strobe, one per received byte.
- `out_data` out 8: current payload byte.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream accepts the byte.
- `out_last` out 1: the byte on `out_data` is the final payload byte.
- `frame_vld` out 1: one-cycle pulse when a complete frame has been accepted.
- `frame_len` out LEN_W: payload length of the last good frame; held until the next good frame.
- `err` out 1: one-cycle fault pulse.
- `err_code` out 3: fault code; held until the next `err`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Control byte constants: SOH=8'h01, STX=8'h02, ETX=8'h03, EOT=8'h04.
- FSM states: IDLE, HDR, PAYLOAD, TRL, DRAIN. All transitions below occur only on cycles with `vald_data`=1, except DRAIN exit and timeout.
- IDLE:
  - SOH → HDR.
  - Any other byte is discarded silently.
- HDR:
  - STX → PAYLOAD, with the write pointer cleared.
  - Any other byte → IDLE, err code 1 (BAD_HDR).
- PAYLOAD:
  - ETX → TRL.
  - SOH → HDR, err code 4 (RESYNC). The partial payload is discarded.
  - Any other byte with wr_ptr<MAX_LEN: store at `buf[wr_ptr]`, then wr_ptr+1.
  - Any other byte with wr_ptr==MAX_LEN → IDLE, err code 2 (OVERFLOW).
  - STX, EOT, CR and LF are ordinary payload bytes.
- TRL:
  - EOT: pulse `frame_vld` and set `frame_len`=wr_ptr.
    - wr_ptr==0 → IDLE; no stream is produced.
    - Otherwise → DRAIN with rd_ptr=0.
  - Any other byte → IDLE, err code 3 (BAD_TRL).
- DRAIN:
  - `out_valid`=1, `out_data`=`buf[rd_ptr]`, `out_last`=(rd_ptr==frame_len-1).
  - Each cycle with `out_valid`&&`out_ready`: rd_ptr+1.
  - Acceptance of the last byte → IDLE.
  - Bytes received during DRAIN are ignored. An SOH received during DRAIN additionally raises err code 6 (DROPPED).
- Simultaneous `vald_data` and a stream handshake in DRAIN: both are handled independently in the same cycle.
- Error codes: 1 BAD_HDR, 2 OVERFLOW, 3 BAD_TRL, 4 RESYNC, 5 TIMEOUT, 6 DROPPED. Codes 0 and 7 are unused.

## Timing
- Reset values (all asynchronous on `RST_N`=0):
  - state=IDLE.
  - `out_data`=0, `out_valid`=0, `out_last`=0.
  - `frame_vld`=0, `frame_len`=0.
  - `err`=0, `err_code`=0, `busy`=0.
  - Pointers = 0. Buffer contents are don't-care.
- Reset mid-frame or mid-drain aborts immediately; no `err` or `frame_vld` is emitted.
- `frame_vld` and `err` are registered: they go high the cycle after the triggering `vald_data` sample and are high for exactly one cycle.
- `out_valid` first rises in the same cycle as `frame_vld`.
- Stream rate:
  - Sustained `out_ready`=1 gives one byte per cycle.
  - `out_data`, `out_valid` and `out_last` are stable while `out_valid`&&!`out_ready`.
- After the last byte is accepted, `busy` falls in the next cycle. A new SOH is accepted from that cycle onward.
- Pointer arithmetic uses LEN_W bits and never wraps; overflow is detected before any write at MAX_LEN.

## Configuration
- Macro: `FRAME_RX_TIMEOUT_EN`.
- Defined:
  - An idle counter runs in HDR, PAYLOAD and TRL. It is cleared on every `vald_data`.
  - Reaching TIMEOUT_CYC-1 → IDLE, err code 5 (TIMEOUT).
  - The counter is held at 0 in IDLE and DRAIN.
- Undefined: no counter is present and code 5 is never produced. The block waits indefinitely between bytes.

## Structure
- Shared package `frame_rx_pkg`:
  - SOH/STX/ETX/EOT constants.
  - FSM state encodings.
  - ERR_* code constants.
- Sub-module `frame_rx_buf`: MAX_LEN×8 single-write, single-read register buffer.
  - Write port: en, addr, data.
  - Read port: addr → data, combinational.
- The FSM, pointers and timeout counter live in `frame_rx`.

## Test plan
- Good frame: 01 02 41 52 54 59 0D 0A 03 04 with `out_ready`=1.
  - Expect `frame_vld` pulse with `frame_len`=6.
  - Expect the stream 41 52 54 59 0D 0A, with `out_last` only on 0A.
  - `busy` low afterwards.
- Empty frame and back-pressure:
  - Empty frame 01 02 03 04: expect `frame_vld` with `frame_len`=0, `out_valid` never high.
  - Then "01 02 41 03 04" with `out_ready` toggled 0/1: expect 41 held stable until accepted.
- Header and trailer faults:
  - 01 41 → err code 1, state IDLE.
  - 01 02 41 03 41 → err code 3, no `frame_vld`.
- Overflow and resync (MAX_LEN=16):
  - 01 02 followed by 17 bytes of 41 → err code 2 on the 17th byte.
  - Separately, 01 02 41 01 02 42 03 04 → err code 4, then `frame_len`=1 with stream byte 42.
- Drop during drain: hold `out_ready`=0 after a good frame and send 01. Expect err code 6, with the stream continuing intact once `out_ready`=1.
- Reset and timeout:
  - Assert `RST_N`=0 mid-PAYLOAD: all outputs return to reset values asynchronously.
  - With `FRAME_RX_TIMEOUT_EN`, TIMEOUT_CYC=100, send 01 02 41 and then idle for 100 cycles: expect err code 5 and state IDLE.

Source files
------------

// File: rtl/frame_rx_pkg.sv
// Shared constants for the UART receive framing decoder: control bytes,
// FSM state encodings and fault codes.
package frame_rx_pkg;

   localparam logic [7:0] SOH = 8'h01;
   localparam logic [7:0] STX = 8'h02;
   localparam logic [7:0] ETX = 8'h03;
   localparam logic [7:0] EOT = 8'h04;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_TRL     = 3'd3,
      ST_DRAIN   = 3'd4
   } state_t;

   localparam logic [2:0] ERR_BAD_HDR  = 3'd1;
   localparam logic [2:0] ERR_OVERFLOW = 3'd2;
   localparam logic [2:0] ERR_BAD_TRL  = 3'd3;
   localparam logic [2:0] ERR_RESYNC   = 3'd4;
   localparam logic [2:0] ERR_TIMEOUT  = 3'd5;
   localparam logic [2:0] ERR_DROPPED  = 3'd6;

endpackage

// File: rtl/frame_rx_buf.sv
// Payload buffer for frame_rx: MAX_LEN x 8 register file, one synchronous
// write port and one combinational read port.
module frame_rx_buf #(
   parameter int MAX_LEN = 16,
   parameter int ADDR_W  = 4
) (
   input  logic              CLK,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data
);

   logic [7:0] mem [MAX_LEN];

   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/frame_rx.sv
// Receive-side framing decoder: SOH STX payload ETX EOT, buffered payload
// streamed out on valid/ready. Optional inter-byte timeout via FRAME_RX_TIMEOUT_EN.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | hunting for SOH, other bytes dropped silently
// ST_HDR     | SOH seen, expecting STX
// ST_PAYLOAD | storing payload bytes until ETX
// ST_TRL     | ETX seen, expecting EOT
// ST_DRAIN   | streaming buffered payload to downstream
module frame_rx
   import frame_rx_pkg::*;
#(
   parameter int MAX_LEN     = 16,
   parameter int LEN_W       = 5,
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [7:0]       recv_data,
   input  logic             vald_data,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             frame_vld,
   output logic [LEN_W-1:0] frame_len,
   output logic             err,
   output logic [2:0]       err_code,
   output logic             busy
);

   localparam int               ADDR_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

   state_t           state, state_nxt;
   logic [LEN_W-1:0] wr_ptr, wr_ptr_nxt;
   logic [LEN_W-1:0] rd_ptr, rd_ptr_nxt;
   logic [LEN_W-1:0] frame_len_nxt;
   logic             frame_vld_nxt;
   logic             err_nxt;
   logic [2:0]       err_code_nxt;
   logic             wr_en;
   logic [7:0]       rd_data;
   logic             timeout_hit;

   frame_rx_buf #(
      .MAX_LEN (MAX_LEN),
      .ADDR_W  (ADDR_W)
   ) u_buf (
      .CLK     (CLK),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr[ADDR_W-1:0]),
      .wr_data (recv_data),
      .rd_addr (rd_ptr[ADDR_W-1:0]),
      .rd_data (rd_data)
   );

`ifdef FRAME_RX_TIMEOUT_EN
   localparam int             TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   logic [TMO_W-1:0] idle_cnt;
   logic             tmo_run;

   assign tmo_run     = (state == ST_HDR) || (state == ST_PAYLOAD) || (state == ST_TRL);
   assign timeout_hit = tmo_run && !vald_data && (idle_cnt == TMO_LAST);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         idle_cnt <= '0;
      end else if (!tmo_run || vald_data || timeout_hit) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + TMO_W'(1);
      end
   end
`else
   // Without the counter the block waits forever; this term is constant 0.
   assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

   assign busy      = (state != ST_IDLE);
   assign out_valid = (state == ST_DRAIN);
   assign out_data  = out_valid ? rd_data : 8'h00;
   assign out_last  = out_valid && (rd_ptr == frame_len - LEN_W'(1));

   always_comb begin
      state_nxt     = state;
      wr_ptr_nxt    = wr_ptr;
      rd_ptr_nxt    = rd_ptr;
      frame_len_nxt = frame_len;
      frame_vld_nxt = 1'b0;
      err_nxt       = 1'b0;
      err_code_nxt  = err_code;
      wr_en         = 1'b0;

      case (state)
         ST_IDLE: begin
            if (vald_data && recv_data == SOH) begin
               state_nxt = ST_HDR;
            end
         end
         ST_HDR: begin
            if (vald_data) begin
               if (recv_data == STX) begin
                  state_nxt  = ST_PAYLOAD;
                  wr_ptr_nxt = '0;
               end else begin
                  state_nxt    = ST_IDLE;
                  err_nxt      = 1'b1;
                  err_code_nxt = ERR_BAD_HDR;
               end
            end
         end
         ST_PAYLOAD: begin
            if (vald_data) begin
               if (recv_data == ETX) begin
                  state_nxt = ST_TRL;
               end else if (recv_data == SOH) begin
                  state_nxt    = ST_HDR;
                  err_nxt      = 1'b1;
                  err_code_nxt = ERR_RESYNC;
               end else if (wr_ptr < LEN_MAX) begin
                  wr_en      = 1'b1;
                  wr_ptr_nxt = wr_ptr + LEN_W'(1);
               end else begin
                  state_nxt    = ST_IDLE;
                  err_nxt      = 1'b1;
                  err_code_nxt = ERR_OVERFLOW;
               end
            end
         end
         ST_TRL: begin
            if (vald_data) begin
               if (recv_data == EOT) begin
                  frame_vld_nxt = 1'b1;
                  frame_len_nxt = wr_ptr;
                  rd_ptr_nxt    = '0;
                  state_nxt     = (wr_ptr == '0) ? ST_IDLE : ST_DRAIN;
               end else begin
                  state_nxt    = ST_IDLE;
                  err_nxt      = 1'b1;
                  err_code_nxt = ERR_BAD_TRL;
               end
            end
         end
         ST_DRAIN: begin
            // Stream handshake and incoming bytes are independent here.
            if (out_ready) begin
               if (out_last) begin
                  state_nxt  = ST_IDLE;
                  rd_ptr_nxt = '0;
               end else begin
                  rd_ptr_nxt = rd_ptr + LEN_W'(1);
               end
            end
            if (vald_data && recv_data == SOH) begin
               err_nxt      = 1'b1;
               err_code_nxt = ERR_DROPPED;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      if (timeout_hit) begin
         state_nxt    = ST_IDLE;
         err_nxt      = 1'b1;
         err_code_nxt = ERR_TIMEOUT;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= ST_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         frame_len <= '0;
         frame_vld <= 1'b0;
         err       <= 1'b0;
         err_code  <= '0;
      end else begin
         state     <= state_nxt;
         wr_ptr    <= wr_ptr_nxt;
         rd_ptr    <= rd_ptr_nxt;
         frame_len <= frame_len_nxt;
         frame_vld <= frame_vld_nxt;
         err       <= err_nxt;
         err_code  <= err_code_nxt;
      end
   end

endmodule
